// File: rtl/atmos_light_est.sv
// Atmospheric light estimator: per frame, picks the pixel with the largest dark channel.
// Optional macro ALIGHT_IIR_EN smooths the per-frame result with a 3/4 : 1/4 temporal filter.
module atmos_light_est (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic       i_eof,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_Ar,
  output logic [7:0] o_Ag,
  output logic [7:0] o_Ab,
  output logic [7:0] o_dmax,
  output logic       o_a_valid
);

  logic [7:0]      pix_dark;
  logic            s1_valid;
  logic            s1_sof;
  logic            s1_eof;
  logic [7:0]      s1_dark;
  logic [2:0][7:0] s1_rgb;
  logic            in_frame;
  logic            done;
  logic [7:0]      max_dark;
  logic [2:0][7:0] max_rgb;
  logic [2:0][7:0] out_rgb;
  logic [7:0]      out_dmax;
  logic [2:0][7:0] next_rgb;
  logic [7:0]      next_dmax;

  always_comb begin
    pix_dark = i_r;
    if (i_g < pix_dark) pix_dark = i_g;
    if (i_b < pix_dark) pix_dark = i_b;
  end

  // Stage 1: register the accepted pixel together with its dark channel.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_dark  <= '0;
      s1_rgb   <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_sof  <= i_sof;
        s1_eof  <= i_eof;
        s1_dark <= pix_dark;
        s1_rgb  <= {i_b, i_g, i_r};
      end
    end
  end

  // Stage 2: running maximum; strict compare keeps the earliest pixel on ties.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_frame <= 1'b0;
      done     <= 1'b0;
      max_dark <= '0;
      max_rgb  <= '0;
    end else begin
      done <= 1'b0;
      if (s1_valid) begin
        if (s1_sof) begin
          max_dark <= s1_dark;
          max_rgb  <= s1_rgb;
          in_frame <= ~s1_eof;
          done     <= s1_eof;
        end else if (in_frame) begin
          if (s1_dark > max_dark) begin
            max_dark <= s1_dark;
            max_rgb  <= s1_rgb;
          end
          if (s1_eof) begin
            in_frame <= 1'b0;
            done     <= 1'b1;
          end
        end
      end
    end
  end

`ifdef ALIGHT_IIR_EN
  logic first;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) first <= 1'b1;
    else if (done) first <= 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_iir
      logic [9:0] acc;
      assign acc          = 10'd3 * {2'b00, out_rgb[gi]} + {2'b00, max_rgb[gi]} + 10'd2;
      assign next_rgb[gi] = first ? max_rgb[gi] : 8'(acc >> 2);
    end
  endgenerate

  always_comb begin
    next_dmax = next_rgb[0];
    if (next_rgb[1] < next_dmax) next_dmax = next_rgb[1];
    if (next_rgb[2] < next_dmax) next_dmax = next_rgb[2];
  end
`else
  assign next_rgb  = max_rgb;
  assign next_dmax = max_dark;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_rgb   <= {3{8'd255}};
      out_dmax  <= 8'd255;
      o_a_valid <= 1'b0;
    end else begin
      o_a_valid <= done;
      if (done) begin
        out_rgb  <= next_rgb;
        out_dmax <= next_dmax;
      end
    end
  end

  assign o_Ar   = out_rgb[0];
  assign o_Ag   = out_rgb[1];
  assign o_Ab   = out_rgb[2];
  assign o_dmax = out_dmax;

endmodule

// File: tb/tb_atmos_light_est.sv
// Bench for atmos_light_est: frame-level reference model plus fixed vectors and corner sequences.
module tb_atmos_light_est;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       sof = 1'b0;
  logic       eof = 1'b0;
  logic [7:0] r_in = '0;
  logic [7:0] g_in = '0;
  logic [7:0] b_in = '0;
  logic [7:0] a_r, a_g, a_b, dmax;
  logic       a_valid;

  atmos_light_est dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_sof(sof), .i_eof(eof),
    .i_r(r_in), .i_g(g_in), .i_b(b_in),
    .o_Ar(a_r), .o_Ag(a_g), .o_Ab(a_b), .o_dmax(dmax), .o_a_valid(a_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int r; int g; int b; int d; } ev_t;
  typedef struct { logic [7:0] r, g, b, er, eg, eb, ed; } vec_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  pulses = 0;
  // Reference model state: frame-level view of the stream
  int  cur[3];
  int  cur_d = 0;
  bit  in_frm = 0;
  bit  first = 1;
  int  prev[3];
  int  m_r = 255, m_g = 255, m_b = 255, m_d = 255;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_accept(bit s, bit e, int r, int g, int b, int k);
    int d;
    int a[3];
    ev_t ev;
    d = r;
    if (g < d) d = g;
    if (b < d) d = b;
    if (s) begin
      cur = '{r, g, b}; cur_d = d; in_frm = 1;
    end else if (in_frm && d > cur_d) begin
      cur = '{r, g, b}; cur_d = d;
    end
    if (e && in_frm) begin
      for (int c = 0; c < 3; c++) begin
`ifdef ALIGHT_IIR_EN
        a[c] = first ? cur[c] : (3 * prev[c] + cur[c] + 2) / 4;
`else
        a[c] = cur[c];
`endif
      end
      ev.cyc = k + 2; ev.r = a[0]; ev.g = a[1]; ev.b = a[2];
`ifdef ALIGHT_IIR_EN
      ev.d = a[0];
      if (a[1] < ev.d) ev.d = a[1];
      if (a[2] < ev.d) ev.d = a[2];
`else
      ev.d = cur_d;
`endif
      q.push_back(ev);
      prev = a;
      first = 0;
      in_frm = 0;
    end
  endtask

  // Drive one cycle of input (called just after a falling edge).
  task automatic px(bit v, bit s, bit e, int r, int g, int b);
    valid = v; sof = s; eof = e;
    r_in = 8'(r); g_in = 8'(g); b_in = 8'(b);
    if (v && rst_n) model_accept(s, e, r, g, b, cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) px(0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("reset_async_Ar", a_r, 255);
    chk("reset_async_dmax", dmax, 255);
    chk("reset_async_valid", a_valid, 0);
    q.delete();
    m_r = 255; m_g = 255; m_b = 255; m_d = 255;
    first = 1; in_frm = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    idle(3);
    reset_now();
  endtask

  task automatic chk_out(string name, int r, int g, int b, int d);
    chk({name, "_Ar"}, a_r, r);
    chk({name, "_Ag"}, a_g, g);
    chk({name, "_Ab"}, a_b, b);
    chk({name, "_dmax"}, dmax, d);
  endtask

  // Scoreboard: pulses must land on the predicted cycle; outputs must hold otherwise.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++; n_fail++;
      $display("FAIL missed_pulse: got none expected pulse at cycle %0d", q[0].cyc);
      m_r = q[0].r; m_g = q[0].g; m_b = q[0].b; m_d = q[0].d;
      void'(q.pop_front());
    end
    if (a_valid) begin
      pulses++;
      if (q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL spurious_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        chk("pulse_cycle", cyc, q[0].cyc);
        m_r = q[0].r; m_g = q[0].g; m_b = q[0].b; m_d = q[0].d;
        void'(q.pop_front());
      end
    end
    chk_out("model", m_r, m_g, m_b, m_d);
  end

  vec_t tbl[6];
  int   p0;

  initial begin
    tbl[0] = '{8'd40,  8'd50,  8'd60,  8'd40,  8'd50,  8'd60,  8'd40};
    tbl[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    tbl[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tbl[3] = '{8'd255, 8'd0,   8'd128, 8'd255, 8'd0,   8'd128, 8'd0};
    tbl[4] = '{8'd7,   8'd3,   8'd9,   8'd7,   8'd3,   8'd9,   8'd3};
    tbl[5] = '{8'd200, 8'd201, 8'd199, 8'd200, 8'd201, 8'd199, 8'd199};

    // Reset state while held in reset
    repeat (3) @(negedge clk);
    chk_out("reset_hold", 255, 255, 255, 255);
    chk("reset_hold_valid", a_valid, 0);
    rst_n = 1'b1;
    idle(2);

    // One-pixel frames (sof and eof together), each from a fresh reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      px(1, 1, 1, tbl[i].r, tbl[i].g, tbl[i].b);
      idle(3);
      chk_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].ed);
    end

    // 4-pixel frame with exact pulse timing
    do_reset();
    px(1, 1, 0, 10, 20, 30);
    px(1, 0, 0, 90, 80, 100);
    px(1, 0, 0, 200, 5, 7);
    px(1, 0, 1, 60, 70, 65);
    chk("lat_k_valid", a_valid, 0);
    idle(1);
    chk("lat_k1_valid", a_valid, 0);
    chk_out("lat_k1_hold", 255, 255, 255, 255);
    idle(1);
    chk("lat_k2_valid", a_valid, 1);
    chk_out("frame4", 90, 80, 100, 80);
    idle(1);
    chk("lat_k3_valid", a_valid, 0);

    // Tie keeps the earliest pixel (gap inside the frame)
    do_reset();
    px(1, 1, 0, 50, 60, 70);
    idle(1);
    px(1, 0, 1, 70, 50, 60);
    idle(3);
    chk_out("tie", 50, 60, 70, 50);

    // Restart on second sof, then a lone eof
    do_reset();
    p0 = pulses;
    px(1, 1, 0, 20, 20, 20);
    px(1, 0, 0, 30, 30, 30);
    px(1, 1, 0, 5, 5, 5);
    px(1, 0, 1, 5, 5, 5);
    idle(3);
    chk_out("restart", 5, 5, 5, 5);
    chk("restart_pulses", pulses - p0, 1);
    px(1, 0, 1, 99, 99, 99);
    idle(3);
    chk("lone_eof_pulses", pulses - p0, 1);
    chk_out("lone_eof_hold", 5, 5, 5, 5);

    // Back-to-back one-pixel frames
    do_reset();
    px(1, 1, 1, 100, 100, 100);
    px(1, 1, 1, 200, 200, 200);
    idle(1);
    chk("b2b_first_valid", a_valid, 1);
    chk_out("b2b_first", 100, 100, 100, 100);
    idle(1);
    chk("b2b_second_valid", a_valid, 1);
`ifdef ALIGHT_IIR_EN
    chk_out("b2b_second", 125, 125, 125, 125);
`else
    chk_out("b2b_second", 200, 200, 200, 200);
`endif
    idle(1);
    chk("b2b_after_valid", a_valid, 0);

    // Reset mid-frame, stray eof, then a one-pixel frame
    do_reset();
    px(1, 1, 0, 10, 10, 10);
    px(1, 0, 0, 200, 200, 200);
    reset_now();
    px(1, 0, 1, 1, 1, 1);
    idle(3);
    chk_out("midreset_hold", 255, 255, 255, 255);
    px(1, 1, 1, 40, 50, 60);
    idle(1);
    chk_out("midreset_pending", 255, 255, 255, 255);
    idle(1);
    chk_out("midreset_frame", 40, 50, 60, 40);

    // Random stream against the model, with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) reset_now();
      else px($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 255) & 8'hF8, $urandom_range(0, 255) & 8'hF8,
              $urandom_range(0, 255) & 8'hF8);
    end
    idle(5);
    chk("pending_events", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/atmos_light_est.md
ATMOS_LIGHT_EST -- requirements
Module: atmos_light_est

Interface
REQ-001 The block SHALL have these ports: i_clk  input  1  single clock; all state on its rising edge.
REQ-002 The block SHALL have: i_rst  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have: i_valid  input  1  pixel qualifier; i_r/i_g/i_b/i_sof/i_eof ignored when low.
REQ-004 The block SHALL have: i_sof  input  1  first pixel of frame, raster order.
REQ-005 The block SHALL have: i_eof  input  1  last pixel of frame.
REQ-006 The block SHALL have: i_r, i_g, i_b  input  8 each  hazy pixel channels.
REQ-007 The block SHALL have: o_Ar, o_Ag, o_Ab  output  8 each  atmospheric light per channel, held between updates; feeds scene restoration Arlocal/Aglocal/Ablocal.
REQ-008 The block SHALL have: o_dmax  output  8  dark-channel value of the selected pixel.
REQ-009 The block SHALL have: o_a_valid  output  1  one-cycle pulse when o_Ar/o_Ag/o_Ab/o_dmax update.

Function
REQ-010 Stage 1 SHALL register, per accepted pixel, dark = min(i_r,i_g,i_b) with the pixel's RGB, sof and eof flags.
REQ-011 Stage 2 SHALL keep running max_dark and max_rgb: on sof, load the stage-1 pixel unconditionally; otherwise replace only when dark > max_dark (strict; ties keep the earliest pixel).
REQ-012 A pixel accepted with i_eof at edge k SHALL cause o_Ar/o_Ag/o_Ab/o_dmax to update at edge k+2 and o_a_valid to be high for exactly the cycle after edge k+2; running result includes that eof pixel.
REQ-013 Pipeline SHALL accept one pixel per cycle with no back-pressure; gaps (i_valid low) SHALL not alter state except advancing empty stage-1 bubbles.
REQ-014 Pixel with i_sof and i_eof both high SHALL form a one-pixel frame; A = that pixel.
REQ-015 A new i_sof before i_eof SHALL discard the partial frame and restart; no o_a_valid for the discarded frame.
REQ-016 i_eof with no i_sof since reset or since last eof SHALL be ignored (no update, no pulse).
REQ-017 Outputs SHALL change only at the REQ-012 edge; they hold while the next frame is streamed.
REQ-018 eof of frame N and sof of frame N+1 on consecutive cycles SHALL both be honoured without loss.

Reset
REQ-019 Assertion of i_rst (low) SHALL immediately force o_Ar=o_Ag=o_Ab=8'd255, o_dmax=8'd255, o_a_valid=0, clear pipeline valids and the in-frame flag.
REQ-020 Reset mid-frame SHALL drop the frame; first update after release requires a fresh sof..eof.

Configuration
REQ-021 With macro ALIGHT_IIR_EN defined, each output channel SHALL update as (3*A_prev + A_frame + 2) >> 2 using a 10-bit intermediate, except the first update after reset which loads A_frame directly; o_dmax = min of the three filtered channels.
REQ-022 Without ALIGHT_IIR_EN, outputs SHALL load the frame result directly; latency identical in both builds.

Verification
REQ-023 Reset: hold i_rst low, toggle clock -> o_Ar/o_Ag/o_Ab/o_dmax = 255, o_a_valid = 0.
REQ-024 4-pixel frame (10,20,30),(90,80,100),(200,5,7),(60,70,65) sof first, eof last -> A = (90,80,100), o_dmax = 80, pulse exactly at edge eof+2.
REQ-025 Tie: pixels (50,60,70) then (70,50,60), both dark 50 -> A = (50,60,70).
REQ-026 sof, 2 pixels, second sof (restart), frame (5,5,5) + eof -> single pulse, A = (5,5,5); lone eof afterwards -> no pulse.
REQ-027 Back-to-back frames, no gap, A1=(100,100,100), A2=(200,200,200): default build -> 100 then 200; ALIGHT_IIR_EN build -> 100 then 125.
REQ-028 Reset asserted mid-frame then one-pixel sof+eof frame (40,50,60) -> outputs 255 until update, then (40,50,60), o_dmax 40.
